// File: rtl/seq_addsub16_ctrl_pkg.sv
// Shared types and constants for the sequential 16-bit add/subtract controller.
// Optional feature macro (used in the top): SEQ_ADDSUB_ZN_FLAGS_EN.
package seq_addsub16_ctrl_pkg;

  localparam int WORD_W  = 16;
  localparam int SLICE_W = 6;
  localparam int EXT_W   = 18;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Sign-extend a word to the three-slice internal width.
  function automatic logic [EXT_W-1:0] sign_ext(input logic [WORD_W-1:0] w);
    return {{(EXT_W-WORD_W){w[WORD_W-1]}}, w};
  endfunction

endpackage

// File: rtl/seq_addsub16_ctrl_if.sv
// Request/response bus of the sequential 16-bit add/subtract controller.
// The master issues operands and op select; the slave returns status, result and flags.
interface seq_addsub16_ctrl_if;
  import seq_addsub16_ctrl_pkg::*;

  logic              start;
  logic              op_sub;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] result;
  logic              carry;
  logic              overflow;
  logic              zero;
  logic              negative;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, carry, overflow, zero, negative
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, carry, overflow, zero, negative
  );

endinterface

// File: rtl/seq_addsub16_ctrl_slice_sel.sv
// Combinational slice selector: picks the active 6-bit slice of the extended
// operands and forms the X/Y/Cin drive for the external ripple slice.
// The external slice XORs Y with Cin internally, so for the upper slices Y is
// pre-masked with the incoming carry to leave an effective operand of bx^op_sub.
module seq_addsub_slice_sel
  import seq_addsub16_ctrl_pkg::*;
(
  input  logic [EXT_W-1:0]   ax,
  input  logic [EXT_W-1:0]   bx,
  input  logic [1:0]         slice_idx,
  input  logic               en,
  input  logic               op_sub,
  input  logic               c_reg,
  output logic [SLICE_W-1:0] add_x,
  output logic [SLICE_W-1:0] add_y,
  output logic               add_cin
);

  logic [SLICE_W-1:0] ax_sl;
  logic [SLICE_W-1:0] bx_sl;

  // Select the operand slice covering bits [6k+5:6k].
  always_comb begin
    ax_sl = '0;
    bx_sl = '0;
    case (slice_idx)
      2'd0: begin ax_sl = ax[5:0];   bx_sl = bx[5:0];   end
      2'd1: begin ax_sl = ax[11:6];  bx_sl = bx[11:6];  end
      2'd2: begin ax_sl = ax[17:12]; bx_sl = bx[17:12]; end
      default: ;
    endcase
  end

  // Form the slice drive; the first slice takes op_sub as carry-in (the +1 of two's complement).
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (en) begin
      add_x = ax_sl;
      if (slice_idx == 2'd0) begin
        add_y   = bx_sl;
        add_cin = op_sub;
      end else begin
        add_y   = bx_sl ^ {SLICE_W{op_sub}} ^ {SLICE_W{c_reg}};
        add_cin = c_reg;
      end
    end
  end

endmodule

// File: rtl/seq_addsub16_ctrl.sv
// Sequential 16-bit add/subtract controller driving an external 6-bit ripple
// slice over three cycles, then registering the result and NZCV-style flags.
// Optional feature: define SEQ_ADDSUB_ZN_FLAGS_EN to compute zero/negative;
// otherwise those outputs are tied low.
module seq_addsub16_ctrl
  import seq_addsub16_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  seq_addsub16_ctrl_if.slave  bus,
  output logic [SLICE_W-1:0]  add_x,
  output logic [SLICE_W-1:0]  add_y,
  output logic                add_cin,
  input  logic [SLICE_W-1:0]  add_s,
  input  logic                add_cout
);

  state_t                 state;
  state_t                 state_nxt;
  logic [EXT_W-1:0]       ax;
  logic [EXT_W-1:0]       bx;
  logic                   op_q;
  logic                   c_reg;
  logic [2*SLICE_W-1:0]   r_low;
  logic [WORD_W:0]        r_fin;
  logic [1:0]             slice_idx;
  logic                   slice_en;
  logic [WORD_W-1:0]      result_q;
  logic                   carry_q;
  logic                   overflow_q;
  logic                   unused_add_s_msb;

  // The top slice's MSB is only a sign-extension copy and carries no new information.
  assign unused_add_s_msb = add_s[SLICE_W-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and active slice selection.
  always_comb begin
    state_nxt = state;
    slice_idx = 2'd0;
    slice_en  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = S0;
      S0:   begin state_nxt = S1; slice_en = 1'b1; slice_idx = 2'd0; end
      S1:   begin state_nxt = S2; slice_en = 1'b1; slice_idx = 2'd1; end
      S2:   begin state_nxt = DONE; slice_en = 1'b1; slice_idx = 2'd2; end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  seq_addsub_slice_sel u_slice_sel (
    .ax        (ax),
    .bx        (bx),
    .slice_idx (slice_idx),
    .en        (slice_en),
    .op_sub    (op_q),
    .c_reg     (c_reg),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin)
  );

  // Capture operands at acceptance and collect slice sums and the chained carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax    <= '0;
      bx    <= '0;
      op_q  <= OP_ADD;
      c_reg <= 1'b0;
      r_low <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          ax   <= sign_ext(bus.a);
          bx   <= sign_ext(bus.b);
          op_q <= bus.op_sub;
        end
        S0: begin r_low[5:0]  <= add_s; c_reg <= add_cout; end
        S1: begin r_low[11:6] <= add_s; c_reg <= add_cout; end
        S2: c_reg <= add_cout;
        default: ;
      endcase
    end
  end

  // Final 17-bit value: the last slice is still on add_s when leaving S2.
  assign r_fin = {add_s[SLICE_W-2:0], r_low};

  // Register result, carry and overflow on the S2->DONE edge; held until the next op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == S2) begin
      result_q   <= r_fin[WORD_W-1:0];
      carry_q    <= r_fin[WORD_W] ^ ax[WORD_W-1] ^ (bx[WORD_W-1] ^ op_q);
      overflow_q <= r_fin[WORD_W] ^ r_fin[WORD_W-1];
    end
  end

`ifdef SEQ_ADDSUB_ZN_FLAGS_EN
  logic zero_q;
  logic negative_q;

  // Zero and negative flags captured alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else if (state == S2) begin
      zero_q     <= (r_fin[WORD_W-1:0] == '0);
      negative_q <= r_fin[WORD_W-1];
    end
  end

  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
`else
  assign bus.zero     = 1'b0;
  assign bus.negative = 1'b0;
`endif

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_addsub16_ctrl.sv
// Testbench for seq_addsub16_ctrl with a behavioural 6-bit add/sub slice.
// Honours SEQ_ADDSUB_ZN_FLAGS_EN for the expected zero/negative values.

// Behavioural 6-bit slice: Y is XORed with Cin internally, then X + Y' + Cin.
module FA_6bit_adder (
  input  logic [5:0] X,
  input  logic [5:0] Y,
  input  logic       Cin,
  output logic [5:0] S,
  output logic       Cout,
  output logic       Ov
);
  logic [5:0] yi;
  logic [6:0] sum;
  assign yi   = Y ^ {6{Cin}};
  assign sum  = {1'b0, X} + {1'b0, yi} + {6'd0, Cin};
  assign S    = sum[5:0];
  assign Cout = sum[6];
  assign Ov   = (X[5] == yi[5]) && (S[5] != X[5]);
endmodule

module tb_seq_addsub16_ctrl;

`ifdef SEQ_ADDSUB_ZN_FLAGS_EN
  localparam bit ZN_EN = 1'b1;
`else
  localparam bit ZN_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [5:0] add_x;
  logic [5:0] add_y;
  logic       add_cin;
  logic [5:0] add_s;
  logic       add_cout;
  logic       unused_slice_ov;

  int total = 0;
  int bad   = 0;

  seq_addsub16_ctrl_if bus ();

  seq_addsub16_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  FA_6bit_adder u_slice (
    .X    (add_x),
    .Y    (add_y),
    .Cin  (add_cin),
    .S    (add_s),
    .Cout (add_cout),
    .Ov   (unused_slice_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOp(input string tag, input logic [15:0] res,
                         input logic c, input logic v, input logic z, input logic n);
    checkOutput({tag, "_result"},   bus.result,   res);
    checkOutput({tag, "_carry"},    bus.carry,    c);
    checkOutput({tag, "_overflow"}, bus.overflow, v);
    checkOutput({tag, "_zero"},     bus.zero,     z & ZN_EN);
    checkOutput({tag, "_negative"}, bus.negative, n & ZN_EN);
  endtask

  // Independent reference: plain 17-bit arithmetic, borrow-style carry for subtract.
  task automatic expectOp(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic opv);
    logic [16:0] wide;
    logic [15:0] res;
    logic        c;
    logic        v;
    if (opv) begin
      wide = {1'b0, av} - {1'b0, bv};
      c    = ~wide[16];
    end else begin
      wide = {1'b0, av} + {1'b0, bv};
      c    = wide[16];
    end
    res = wide[15:0];
    if (opv) v = (av[15] != bv[15]) && (res[15] != av[15]);
    else     v = (av[15] == bv[15]) && (res[15] != av[15]);
    checkOp(tag, res, c, v, (res == 16'h0000), res[15]);
  endtask

  // Issue one operation and wait (bounded) for done, checking latency and busy length.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic opv);
    int busy_cycles;
    bit seen;
    @(negedge clk);
    checkOutput("idle_busy", bus.busy, 1'b0);
    bus.start  = 1'b1;
    bus.a      = av;
    bus.b      = bv;
    bus.op_sub = opv;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (i == 0) begin
        checkOutput("s0_cin", add_cin, opv);
        checkOutput("s0_x", add_x, av[5:0]);
      end
      if (bus.done) seen = 1'b1;
    end
    checkOutput("done_seen", seen, 1'b1);
    checkOutput("busy_cycles", busy_cycles, 4);
  endtask

  initial begin
    int done_count;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rop;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOp("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_add_x", add_x, 6'd0);
    checkOutput("rst_add_y", add_y, 6'd0);
    checkOutput("rst_add_cin", add_cin, 1'b0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOp("d1", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOp("d2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0001, 1'b1);
    checkOp("d3", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    checkOp("d4", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("d4_hold_result", bus.result, 16'h7FFF);
    checkOutput("d4_idle_add_x", add_x, 6'd0);

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0111; bus.op_sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.op_sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) done_count++;
      @(negedge clk);
    end
    checkOutput("ign_done_count", done_count, 1);
    checkOp("ign", 16'h1345, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during S2");
    bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0F00; bus.op_sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_done", bus.done, 1'b0);
    checkOutput("abort_result", bus.result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0005, 16'h0003, 1'b1);
    checkOp("post_rst", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] random vectors");
    for (int k = 0; k < 1000; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rop);
      expectOp("rnd", ra, rb, rop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
